// File: rtl/modulo_disp.sv
// modulo_disp: registered seven-segment glyph decoder for note letters or scale degrees
module modulo_disp (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       TOM_module,
    input  logic [2:0] NOTAS,
    output logic [6:0] SAIDA
);
    logic [6:0] saida_d;
    logic [6:0] saida_q;

    // Decode {mode, note} into an active-low a..g pattern; the letter rest and any unknown code fall to blank
    always_comb begin
        saida_d = 7'b1111111;
        case ({TOM_module, NOTAS})
            4'b0000: saida_d = 7'b0110001;
            4'b0001: saida_d = 7'b1000010;
            4'b0010: saida_d = 7'b0110000;
            4'b0011: saida_d = 7'b0111000;
            4'b0100: saida_d = 7'b0100001;
            4'b0101: saida_d = 7'b0001000;
            4'b0110: saida_d = 7'b1100000;
            4'b1000: saida_d = 7'b1001111;
            4'b1001: saida_d = 7'b0010010;
            4'b1010: saida_d = 7'b0000110;
            4'b1011: saida_d = 7'b1001100;
            4'b1100: saida_d = 7'b0100100;
            4'b1101: saida_d = 7'b0100000;
            4'b1110: saida_d = 7'b0001111;
            4'b1111: saida_d = 7'b1111110;
            default: saida_d = 7'b1111111;
        endcase
    end

    // Register the glyph so the pins never glitch; reset blanks the digit immediately
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) saida_q <= 7'b1111111;
        else          saida_q <= saida_d;
    end

    assign SAIDA = saida_q;
endmodule

// File: tb/tb_modulo_disp.sv
// tb_modulo_disp: directed self-checking bench for the note glyph decoder
module tb_modulo_disp;
    logic       CLK;
    logic       RESET_N;
    logic       TOM_module;
    logic [2:0] NOTAS;
    logic [6:0] SAIDA;
    int total = 0;
    int bad = 0;
    logic [6:0] prev;
    logic [6:0] exp;

    logic [6:0] lt [8] = '{7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000,
                           7'b0100001, 7'b0001000, 7'b1100000, 7'b1111111};
    logic [6:0] dg [8] = '{7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                           7'b0100100, 7'b0100000, 7'b0001111, 7'b1111110};

    modulo_disp dut (
        .CLK(CLK),
        .RESET_N(RESET_N),
        .TOM_module(TOM_module),
        .NOTAS(NOTAS),
        .SAIDA(SAIDA)
    );

    initial begin
        CLK = 0;
        forever #5 CLK = ~CLK;
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        TOM_module = 0;
        NOTAS = 3'b000;
        RESET_N = 1;
        #1 RESET_N = 0;
        #1;
        total++;
        if (SAIDA !== 7'b1111111) begin bad++; $display("FAIL reset_async: SAIDA=%b expected=%b", SAIDA, 7'b1111111); end
        for (int i = 0; i < 3; i++) begin
            tick;
            total++;
            if (SAIDA !== 7'b1111111) begin bad++; $display("FAIL reset_hold[%0d]: SAIDA=%b expected=%b", i, SAIDA, 7'b1111111); end
        end
        @(negedge CLK);
        RESET_N = 1;
        #1;
        total++;
        if (SAIDA !== 7'b1111111) begin bad++; $display("FAIL reset_release_noedge: SAIDA=%b expected=%b", SAIDA, 7'b1111111); end
        tick;
        total++;
        if (SAIDA !== 7'b0110001) begin bad++; $display("FAIL reset_first_edge: SAIDA=%b expected=%b", SAIDA, 7'b0110001); end
    endtask

    task automatic test_letters;
        TOM_module = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            NOTAS = 3'(i);
            tick;
            total++;
            if (SAIDA !== lt[i]) begin bad++; $display("FAIL letter[%0d]: SAIDA=%b expected=%b", i, SAIDA, lt[i]); end
            tick;
            total++;
            if (SAIDA !== lt[i]) begin bad++; $display("FAIL letter_hold[%0d]: SAIDA=%b expected=%b", i, SAIDA, lt[i]); end
        end
    endtask

    task automatic test_degrees;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            TOM_module = 1;
            NOTAS = 3'(i);
            tick;
            total++;
            if (SAIDA !== dg[i]) begin bad++; $display("FAIL degree[%0d]: SAIDA=%b expected=%b", i, SAIDA, dg[i]); end
            tick;
            total++;
            if (SAIDA !== dg[i]) begin bad++; $display("FAIL degree_hold[%0d]: SAIDA=%b expected=%b", i, SAIDA, dg[i]); end
        end
    endtask

    task automatic test_mode_flip;
        prev = 7'b1111110;
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            NOTAS = 3'b101;
            TOM_module = k[0];
            exp = k[0] ? 7'b0100000 : 7'b0001000;
            #1;
            total++;
            if (SAIDA !== prev) begin bad++; $display("FAIL flip_lag[%0d]: SAIDA=%b expected=%b", k, SAIDA, prev); end
            tick;
            total++;
            if (SAIDA !== exp) begin bad++; $display("FAIL flip[%0d]: SAIDA=%b expected=%b", k, SAIDA, exp); end
            prev = exp;
        end
    endtask

    task automatic test_async_reset;
        @(negedge CLK);
        TOM_module = 1;
        NOTAS = 3'b001;
        tick;
        total++;
        if (SAIDA !== 7'b0010010) begin bad++; $display("FAIL arst_before: SAIDA=%b expected=%b", SAIDA, 7'b0010010); end
        @(negedge CLK);
        #2 RESET_N = 0;
        #1;
        total++;
        if (SAIDA !== 7'b1111111) begin bad++; $display("FAIL arst_immediate: SAIDA=%b expected=%b", SAIDA, 7'b1111111); end
        tick;
        total++;
        if (SAIDA !== 7'b1111111) begin bad++; $display("FAIL arst_held: SAIDA=%b expected=%b", SAIDA, 7'b1111111); end
        @(negedge CLK);
        RESET_N = 1;
        #1;
        total++;
        if (SAIDA !== 7'b1111111) begin bad++; $display("FAIL arst_release_noedge: SAIDA=%b expected=%b", SAIDA, 7'b1111111); end
        tick;
        total++;
        if (SAIDA !== 7'b0010010) begin bad++; $display("FAIL arst_after: SAIDA=%b expected=%b", SAIDA, 7'b0010010); end
    endtask

    task automatic test_back_to_back;
        for (int c = 0; c < 16; c++) begin
            @(negedge CLK);
            {TOM_module, NOTAS} = 4'(c);
            exp = (c < 8) ? lt[c] : dg[c - 8];
            tick;
            total++;
            if (SAIDA !== exp) begin bad++; $display("FAIL b2b[%0d]: SAIDA=%b expected=%b", c, SAIDA, exp); end
        end
    endtask

    initial begin
        test_reset;
        test_letters;
        test_degrees;
        test_mode_flip;
        test_async_reset;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
